screen_hub75_rx: RTL

- HUB75 sink that receives the serial stream from the 32x32 LED-matrix driver: clk_screen, R0/G0/B0, R1/G1/B1, blank, latch and row.
- Rebuilds each latched line into a line buffer, then emits it as a pixel-write stream (x, y, rgb) with a valid/ready handshake.
- Sits on the far side of the screen peripheral, either as a panel model on the SoC bench or as a capture block feeding a framebuffer checker.

---
 rtl/screen_hub75_rx_if.sv | 14 +
 rtl/screen_hub75_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/screen_hub75_rx_if.sv
// screen_hub75_rx_if: pixel-write stream (x, y, rgb) with valid/ready handshake.
interface screen_hub75_rx_if #(
  parameter int unsigned XW = 5,
  parameter int unsigned YW = 5
);
  logic          pix_valid;
  logic          pix_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [2:0]    pix_rgb;

  modport master (output pix_valid, pix_x, pix_y, pix_rgb, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_rgb, output pix_ready);
endinterface

// File: rtl/screen_hub75_rx.sv
// screen_hub75_rx: HUB75 sink that rebuilds latched lines and replays them as pixel writes.
// Optional: define SCREEN_RX_BLANK_CHECK_EN to add the err_blank sticky flag.
module screen_hub75_rx #(
  parameter int unsigned COLS = 32,
  parameter int unsigned HALF = 16,
  parameter int unsigned XW   = 5,
  parameter int unsigned YW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_screen,
  input  logic       R0,
  input  logic       G0,
  input  logic       B0,
  input  logic       R1,
  input  logic       G1,
  input  logic       B1,
  input  logic       blank,
  input  logic       latch,
  input  logic [4:0] row,
  screen_hub75_rx_if.master pix,
  output logic       frame_done,
  input  logic       err_clr,
  output logic       err_under,
  output logic       err_over,
  output logic       err_drop
`ifdef SCREEN_RX_BLANK_CHECK_EN
  ,
  output logic       err_blank
`endif
);

  localparam int unsigned CW   = $clog2(COLS + 2);
  localparam int unsigned IW   = XW + 1;
  localparam int unsigned LAST = 2 * COLS - 1;
`ifdef SCREEN_RX_BLANK_CHECK_EN
  localparam int unsigned SW = 14;
`else
  localparam int unsigned SW = 13;
`endif

  typedef enum logic {IDLE, EMIT} state_t;

  logic [SW-1:0] raw, s1, s2;
  logic          clk_d, latch_d;
  logic [5:0]    data_s;
  logic          clk_s, latch_s;
  logic [4:0]    row_s;

`ifdef SCREEN_RX_BLANK_CHECK_EN
  assign raw = {blank, row, latch, clk_screen, R0, G0, B0, R1, G1, B1};
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign raw = {row, latch, clk_screen, R0, G0, B0, R1, G1, B1};
`endif

  assign data_s  = s2[5:0];
  assign clk_s   = s2[6];
  assign latch_s = s2[7];
  assign row_s   = s2[12:8];

  // Common two-flop synchronizer; data and strobes come from the same stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      clk_d   <= 1'b0;
      latch_d <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      clk_d   <= clk_s;
      latch_d <= latch_s;
    end
  end

  state_t                state, state_n;
  logic                  shift_rise, latch_rise;
  logic [COLS-1:0][5:0]  sr, sr_next, lb;
  logic [CW-1:0]         shift_cnt, cnt_eff;
  logic                  drop, under, over, take;

  assign shift_rise = clk_s & ~clk_d;
  assign latch_rise = latch_s & ~latch_d;

  // A shift coincident with a latch is applied before the count is judged.
  assign sr_next = shift_rise ? {sr[COLS-2:0], data_s} : sr;
  assign cnt_eff = (shift_rise && (shift_cnt != CW'(COLS + 1))) ? shift_cnt + CW'(1) : shift_cnt;

  assign drop  = latch_rise && ((state == EMIT) || (row_s >= 5'(HALF)));
  assign under = latch_rise && !drop && (cnt_eff < CW'(COLS));
  assign over  = latch_rise && !drop && (cnt_eff > CW'(COLS));
  assign take  = latch_rise && !drop && !under;

  always_ff @(posedge clk) begin
    if (rst)             shift_cnt <= '0;
    else if (latch_rise) shift_cnt <= '0;
    else                 shift_cnt <= cnt_eff;
  end

  always_ff @(posedge clk) begin
    sr <= sr_next;
    if (take) lb <= sr_next;
  end

  logic [IW-1:0] idx, idx_n;
  logic          valid_q, valid_n, done_n;
  logic [XW-1:0] x_q, x_n;
  logic [YW-1:0] y_q, y_n, row_q;
  logic [2:0]    rgb_q, rgb_n;

  // Emit sequencer: upper half columns first, then lower half.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    valid_n = valid_q;
    done_n  = 1'b0;
    x_n     = x_q;
    y_n     = y_q;
    rgb_n   = rgb_q;
    case (state)
      IDLE: begin
        if (take) begin
          state_n = EMIT;
          idx_n   = '0;
          valid_n = 1'b1;
          x_n     = '0;
          y_n     = YW'(row_s);
          rgb_n   = sr_next[0][5:3];
        end
      end
      EMIT: begin
        if (valid_q && pix.pix_ready) begin
          if (idx == IW'(LAST)) begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = (row_q == YW'(HALF - 1));
          end else begin
            idx_n = idx + IW'(1);
            x_n   = idx_n[XW-1:0];
            y_n   = idx_n[XW] ? row_q + YW'(HALF) : row_q;
            rgb_n = idx_n[XW] ? lb[idx_n[XW-1:0]][2:0] : lb[idx_n[XW-1:0]][5:3];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rgb_q      <= '0;
      row_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      valid_q    <= valid_n;
      x_q        <= x_n;
      y_q        <= y_n;
      rgb_q      <= rgb_n;
      frame_done <= done_n;
      if (take) row_q <= YW'(row_s);
    end
  end

  assign pix.pix_valid = valid_q;
  assign pix.pix_x     = x_q;
  assign pix.pix_y     = y_q;
  assign pix.pix_rgb   = rgb_q;

  // Sticky flags: a set event in the clearing cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_under <= 1'b0;
      err_over  <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      err_under <= under | (err_under & ~err_clr);
      err_over  <= over  | (err_over  & ~err_clr);
      err_drop  <= drop  | (err_drop  & ~err_clr);
    end
  end

`ifdef SCREEN_RX_BLANK_CHECK_EN
  logic [4:0] row_d;
  logic       blank_s, blank_hit;

  assign blank_s   = s2[13];
  assign blank_hit = !blank_s && (latch_rise || (row_s != row_d));

  // Latching or re-addressing while the panel is lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_d     <= '0;
      err_blank <= 1'b0;
    end else begin
      row_d     <= row_s;
      err_blank <= blank_hit | (err_blank & ~err_clr);
    end
  end
`endif

endmodule
